// File: rtl/problema1_processor_oci_pkg.sv
// Shared types for the processor OCI debug blocks.
// The capture FSM encoding is fixed so that other tools can decode it.
package problema1_processor_oci_pkg;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        DRAIN   = 2'd1,
        ENDED   = 2'd2
    } dct_state_e;

endpackage : problema1_processor_oci_pkg

// File: rtl/problema1_processor_oci_dct_capture_if.sv
// Trace-capture bus: producer side (trace words, end-of-test request) and
// consumer side (show-ahead read port, status flags).
interface problema1_processor_oci_dct_capture_if #(
    parameter int DATA_W = 30,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              dct_valid;
    logic [DATA_W-1:0] dct_buffer;
    logic              test_ending;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  dct_count;
    logic              overflow;
    logic              test_has_ended;

    modport master (
        output dct_valid, dct_buffer, test_ending, rd_ready,
        input  rd_valid, rd_data, dct_count, overflow, test_has_ended
    );

    modport slave (
        input  dct_valid, dct_buffer, test_ending, rd_ready,
        output rd_valid, rd_data, dct_count, overflow, test_has_ended
    );

endinterface : problema1_processor_oci_dct_capture_if

// File: rtl/problema1_processor_oci_dct_ram.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
module problema1_processor_oci_dct_ram #(
    parameter int DATA_W = 30,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; validity is tracked by the pointers and
    // count, so clearing it would only cost area.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : problema1_processor_oci_dct_ram

// File: rtl/problema1_processor_oci_dct_capture.sv
// Debug trace capture buffer: stores trace words until the test ends, then
// drains them to the consumer and raises test_has_ended once empty.
module problema1_processor_oci_dct_capture
    import problema1_processor_oci_pkg::*;
#(
    parameter int DATA_W = 30,
    parameter int DEPTH  = 16
) (
    input  logic clk,
    input  logic reset_n,
    problema1_processor_oci_dct_capture_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    dct_state_e       state, state_next;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic             overflow_q;
    logic             do_wr, do_rd, drop;

    // A full buffer still accepts a word when a read frees a slot this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        do_rd      = (count != '0) && bus.rd_ready;
        do_wr      = bus.dct_valid && (state == CAPTURE) && ((count != FULL) || do_rd);
        drop       = bus.dct_valid && (state == CAPTURE) && (count == FULL) && !do_rd;
        count_next = count;
        case ({do_wr, do_rd})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            CAPTURE: if (bus.test_ending) state_next = DRAIN;
            DRAIN:   if (count_next == '0) state_next = ENDED;
            ENDED:   state_next = ENDED;
            default: state_next = CAPTURE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= CAPTURE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            if (drop)  overflow_q <= 1'b1;
        end
    end

    problema1_processor_oci_dct_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wr_ptr),
        .wdata (bus.dct_buffer),
        .raddr (rd_ptr),
        .rdata (bus.rd_data)
    );

    assign bus.rd_valid       = (count != '0);
    assign bus.dct_count      = count;
    assign bus.overflow       = overflow_q;
    assign bus.test_has_ended = (state == ENDED);

endmodule : problema1_processor_oci_dct_capture
